// File: rtl/seg_stim_seq_if.sv
// seg_stim_seq_if: signal bundle between the stimulus owner (bench) and seg_stim_seq.
//
// Groups the step-table write port, sequence control, the uart_tx handshake
// and the channel/status outputs. clk and rst are not part of the bundle.
//
//   master : drives wr_*, num_steps, loop, start, stop, cmd_sent
//   slave  : drives ch_val, send_cmd, cmd, busy, step_idx, done, tx_err

interface seg_stim_seq_if #(
    parameter int unsigned N_CH   = 5,
    parameter int unsigned CH_W   = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned HOLD_W = 24
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NW = $clog2(DEPTH + 1);

    // Table write port
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic                   wr_cmd_vld;
    logic [7:0]             wr_cmd;
    logic [N_CH*CH_W-1:0]   wr_ch;
    logic [HOLD_W-1:0]      wr_hold;

    // Sequence control
    logic [NW-1:0]          num_steps;
    logic                   loop;
    logic                   start;
    logic                   stop;

    // uart_tx handshake
    logic                   send_cmd;
    logic [7:0]             cmd;
    logic                   cmd_sent;

    // Stimulus and status
    logic [N_CH*CH_W-1:0]   ch_val;
    logic                   busy;
    logic [AW-1:0]          step_idx;
    logic                   done;
    logic                   tx_err;

    modport master (
        output wr_en, wr_addr, wr_cmd_vld, wr_cmd, wr_ch, wr_hold,
        output num_steps, loop, start, stop, cmd_sent,
        input  ch_val, send_cmd, cmd, busy, step_idx, done, tx_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_cmd_vld, wr_cmd, wr_ch, wr_hold,
        input  num_steps, loop, start, stop, cmd_sent,
        output ch_val, send_cmd, cmd, busy, step_idx, done, tx_err
    );
endinterface

// File: rtl/seg_stim_seq.sv
// seg_stim_seq: programmable stimulus sequencer for the Segway environment.
//
// A DEPTH-entry step table holds, per step, N_CH channel values, an optional
// command byte and a hold count. Once started the sequencer walks the table:
// it drives the channel values, optionally pushes the command byte through the
// uart_tx trmt/tx_done handshake, then holds for h+1 cycles. One-shot and
// loop modes; a transmitter that never answers raises a sticky tx_err.
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset (also clears the step table)
//   bus  : seg_stim_seq_if.slave -- table write port, start/stop/num_steps/loop,
//          cmd_sent in; ch_val, send_cmd, cmd, busy, step_idx, done, tx_err out

module seg_stim_seq #(
    parameter int unsigned N_CH   = 5,
    parameter int unsigned CH_W   = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned HOLD_W = 24,
    parameter int unsigned TX_TO  = 4096
) (
    input  logic           clk,
    input  logic           rst,
    seg_stim_seq_if.slave  bus
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned NW  = $clog2(DEPTH + 1);
    localparam int unsigned TOW = (TX_TO > 1) ? $clog2(TX_TO) : 1;
    localparam int unsigned CHB = N_CH * CH_W;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSend,
        StWaitTx,
        StHold,
        StDone
    } state_e;

    // Step table
    logic [CHB-1:0]    tbl_ch   [DEPTH];
    logic [7:0]        tbl_cmd  [DEPTH];
    logic              tbl_vld  [DEPTH];
    logic [HOLD_W-1:0] tbl_hold [DEPTH];

    state_e            state_q, state_d;
    logic [AW-1:0]     step_q, step_d;
    logic [NW-1:0]     n_q, n_d;
    logic              loop_q, loop_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [TOW-1:0]    to_q, to_d;
    logic [CHB-1:0]    ch_q, ch_d;
    logic [7:0]        cmd_q, cmd_d;
    logic              tx_err_q, tx_err_d;
    logic              send_cmd, done;
    logic [NW-1:0]     n_clamp;

    assign n_clamp = (bus.num_steps > NW'(DEPTH)) ? NW'(DEPTH) : bus.num_steps;

    // Writes are only taken in IDLE; a write coinciding with start lands before
    // LOAD reads the table, so the new value is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tbl_ch[i]   <= '0;
                tbl_cmd[i]  <= '0;
                tbl_vld[i]  <= 1'b0;
                tbl_hold[i] <= '0;
            end
        end else if (bus.wr_en && state_q == StIdle) begin
            tbl_ch[bus.wr_addr]   <= bus.wr_ch;
            tbl_cmd[bus.wr_addr]  <= bus.wr_cmd;
            tbl_vld[bus.wr_addr]  <= bus.wr_cmd_vld;
            tbl_hold[bus.wr_addr] <= bus.wr_hold;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            step_q   <= '0;
            n_q      <= '0;
            loop_q   <= 1'b0;
            hold_q   <= '0;
            to_q     <= '0;
            ch_q     <= '0;
            cmd_q    <= '0;
            tx_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            n_q      <= n_d;
            loop_q   <= loop_d;
            hold_q   <= hold_d;
            to_q     <= to_d;
            ch_q     <= ch_d;
            cmd_q    <= cmd_d;
            tx_err_q <= tx_err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        n_d      = n_q;
        loop_d   = loop_q;
        hold_d   = hold_q;
        to_d     = to_q;
        ch_d     = ch_q;
        cmd_d    = cmd_q;
        tx_err_d = tx_err_q;
        send_cmd = 1'b0;
        done     = 1'b0;

        // stop overrides everything, including the pulses of SEND and DONE.
        if (bus.stop && state_q != StIdle) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start && !bus.stop) begin
                        n_d      = n_clamp;
                        loop_d   = bus.loop;
                        step_d   = '0;
                        tx_err_d = 1'b0;
                        state_d  = (n_clamp == '0) ? StDone : StLoad;
                    end
                end
                StLoad: begin
                    ch_d  = tbl_ch[step_q];
                    cmd_d = tbl_cmd[step_q];
                    if (tbl_vld[step_q]) begin
                        state_d = StSend;
                    end else begin
                        hold_d  = tbl_hold[step_q];
                        state_d = StHold;
                    end
                end
                StSend: begin
                    send_cmd = 1'b1;
                    to_d     = '0;
                    state_d  = StWaitTx;
                end
                StWaitTx: begin
                    if (bus.cmd_sent) begin
                        hold_d  = tbl_hold[step_q];
                        state_d = StHold;
                    end else if (to_q == TOW'(TX_TO - 1)) begin
                        tx_err_d = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
                StHold: begin
                    if (hold_q != '0) begin
                        hold_d = hold_q - 1'b1;
                    end else if (NW'(step_q) != n_q - NW'(1)) begin
                        step_d  = step_q + 1'b1;
                        state_d = StLoad;
                    end else if (loop_q) begin
                        step_d  = '0;
                        state_d = StLoad;
                    end else begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign bus.ch_val   = ch_q;
    assign bus.cmd      = cmd_q;
    assign bus.send_cmd = send_cmd;
    assign bus.done     = done;
    assign bus.busy     = (state_q != StIdle);
    assign bus.step_idx = step_q;
    assign bus.tx_err   = tx_err_q;

endmodule

// File: tb/tb_seg_stim_seq.sv
// Self-checking bench for seg_stim_seq (DEPTH=16, TX_TO=16).
// Inputs change 1 time unit after a rising edge and outputs are sampled there;
// "now" counts rising edges, so a start driven at now=t is taken at edge t+1.

module tb_seg_stim_seq;
    localparam int unsigned N_CH   = 5;
    localparam int unsigned CH_W   = 16;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned HOLD_W = 24;
    localparam int unsigned TX_TO  = 16;
    localparam int unsigned CHB    = N_CH * CH_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   now = 0;
    int   total = 0;
    int   bad = 0;

    logic [CHB-1:0] exp_ch_q [$];
    int             exp_t_q  [$];
    logic [7:0]     exp_cmd_q[$];

    seg_stim_seq_if #(.N_CH(N_CH), .CH_W(CH_W), .DEPTH(DEPTH), .HOLD_W(HOLD_W)) bus ();

    seg_stim_seq #(
        .N_CH(N_CH), .CH_W(CH_W), .DEPTH(DEPTH), .HOLD_W(HOLD_W), .TX_TO(TX_TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [CHB-1:0] mk_ch(input int s);
        logic [CHB-1:0] v;
        for (int c = 0; c < int'(N_CH); c++) v[c*CH_W +: CH_W] = CH_W'(s * 37 + c * 1001 + 1);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        now++;
    endtask

    task automatic wr_entry(input int a, input logic vld, input logic [7:0] c,
                            input logic [CHB-1:0] ch, input int h);
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 4'(a);
        bus.wr_cmd_vld = vld;
        bus.wr_cmd     = c;
        bus.wr_ch      = ch;
        bus.wr_hold    = HOLD_W'(h);
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic go(input int n, input logic lp);
        bus.num_steps = 5'(n);
        bus.loop      = lp;
        bus.start     = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && bus.busy; i++) tick();
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_wait: busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_reset();
        total++;
        if (bus.ch_val !== '0 || bus.send_cmd !== 1'b0 || bus.cmd !== 8'h00 ||
            bus.busy !== 1'b0 || bus.step_idx !== 4'd0 || bus.done !== 1'b0 ||
            bus.tx_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_vals: ch=%h snd=%b cmd=%h busy=%b idx=%0d done=%b err=%b want all 0",
                     bus.ch_val, bus.send_cmd, bus.cmd, bus.busy, bus.step_idx, bus.done,
                     bus.tx_err);
        end
    endtask

    task automatic test_three_steps();
        logic [CHB-1:0] prev, e;
        int t0, et, done_n, done_t;
        wr_entry(0, 1'b0, 8'h00, mk_ch(1), 4);
        wr_entry(1, 1'b0, 8'h00, mk_ch(2), 0);
        wr_entry(2, 1'b0, 8'h00, mk_ch(3), 9);
        exp_ch_q.push_back(mk_ch(1)); exp_t_q.push_back(2);
        exp_ch_q.push_back(mk_ch(2)); exp_t_q.push_back(8);
        exp_ch_q.push_back(mk_ch(3)); exp_t_q.push_back(10);
        prev = bus.ch_val; t0 = now; done_n = 0; done_t = -1;
        go(3, 1'b0);
        for (int i = 0; i < 25; i++) begin
            tick();
            if (i == 0) bus.start = 1'b0;
            if (bus.ch_val !== prev) begin
                total++;
                if (exp_ch_q.size() == 0) begin
                    bad++;
                    $display("FAIL three_ch_extra: got %h @%0d want no change", bus.ch_val, now - t0);
                end else begin
                    e = exp_ch_q.pop_front(); et = exp_t_q.pop_front();
                    if (bus.ch_val !== e || now - t0 != et) begin
                        bad++;
                        $display("FAIL three_ch: got %h @%0d want %h @%0d", bus.ch_val, now - t0, e, et);
                    end
                end
                prev = bus.ch_val;
            end
            if (bus.done === 1'b1) begin done_n++; done_t = now - t0; end
            if (now - t0 == 21) begin
                total++;
                if (bus.busy !== 1'b0) begin bad++; $display("FAIL three_busy21: got %b want 0", bus.busy); end
            end
        end
        total++;
        if (done_n != 1 || done_t != 20) begin
            bad++;
            $display("FAIL three_done: got n=%0d @%0d want n=1 @20", done_n, done_t);
        end
        total++;
        if (exp_ch_q.size() != 0) begin
            bad++;
            $display("FAIL three_missing: got %0d pending want 0", exp_ch_q.size());
        end
        exp_ch_q.delete(); exp_t_q.delete();
    endtask

    task automatic test_cmd();
        logic [7:0] e;
        int t0, sends, sent_t, done_t;
        wr_entry(0, 1'b1, 8'h67, mk_ch(4), 2);
        exp_cmd_q.push_back(8'h67);
        t0 = now; sends = 0; sent_t = -1; done_t = -1;
        go(1, 1'b0);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 0) bus.start = 1'b0;
            bus.cmd_sent = 1'b0;
            if (bus.send_cmd === 1'b1) begin
                sends++; sent_t = now - t0;
                total++;
                if (exp_cmd_q.size() == 0) begin
                    bad++; $display("FAIL cmd_extra: got %h want no pulse", bus.cmd);
                end else begin
                    e = exp_cmd_q.pop_front();
                    if (bus.cmd !== e) begin bad++; $display("FAIL cmd_byte: got %h want %h", bus.cmd, e); end
                end
            end
            // tx_done after 3 WAIT_TX cycles; the pulse at offset 7 lands in HOLD and must be ignored
            if (sent_t >= 0 && (now - t0 == sent_t + 3 || now - t0 == 7)) bus.cmd_sent = 1'b1;
            if (bus.done === 1'b1) done_t = now - t0;
        end
        bus.cmd_sent = 1'b0;
        total++;
        if (sends != 1 || sent_t != 2) begin
            bad++; $display("FAIL cmd_pulse: got n=%0d @%0d want n=1 @2", sends, sent_t);
        end
        total++;
        if (done_t != 9 || bus.ch_val !== mk_ch(4)) begin
            bad++; $display("FAIL cmd_hold: got done@%0d ch=%h want done@9 ch=%h", done_t, bus.ch_val, mk_ch(4));
        end
        exp_cmd_q.delete();
    endtask

    task automatic test_timeout();
        int t0, t1, done_n;
        wr_entry(0, 1'b1, 8'h5A, mk_ch(5), 0);
        t0 = now; done_n = 0;
        go(1, 1'b0);
        for (int i = 0; i < 22; i++) begin
            tick();
            if (i == 0) bus.start = 1'b0;
            if (bus.done === 1'b1) done_n++;
            if (now - t0 == 18) begin
                total++;
                if (bus.busy !== 1'b1 || bus.tx_err !== 1'b0) begin
                    bad++; $display("FAIL to_early: got busy=%b err=%b want 1 0", bus.busy, bus.tx_err);
                end
            end
            if (now - t0 == 19 || now - t0 == 20) begin
                total++;
                if (bus.busy !== 1'b0 || bus.tx_err !== 1'b1) begin
                    bad++; $display("FAIL to_flag@%0d: got busy=%b err=%b want 0 1", now - t0, bus.busy, bus.tx_err);
                end
            end
        end
        total++;
        if (done_n != 0 || bus.ch_val !== mk_ch(5)) begin
            bad++; $display("FAIL to_nodone: got done_n=%0d ch=%h want 0 %h", done_n, bus.ch_val, mk_ch(5));
        end
        // Next start (num_steps=0) clears tx_err and goes straight to DONE
        t1 = now;
        go(0, 1'b0);
        tick();
        bus.start = 1'b0;
        total++;
        if (now - t1 != 1 || bus.tx_err !== 1'b0 || bus.done !== 1'b1 || bus.ch_val !== mk_ch(5)) begin
            bad++;
            $display("FAIL zero_steps: got err=%b done=%b ch=%h want 0 1 %h", bus.tx_err, bus.done, bus.ch_val, mk_ch(5));
        end
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++; $display("FAIL zero_end: got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_loop_stop();
        int t0;
        logic [3:0] e;
        wr_entry(0, 1'b0, 8'h00, mk_ch(6), 0);
        wr_entry(1, 1'b0, 8'h00, mk_ch(7), 0);
        t0 = now;
        go(2, 1'b1);
        for (int j = 0; j <= 20; j++) begin
            tick();
            if (j == 0) bus.start = 1'b0;
            e = 4'((j / 2) % 2);
            total++;
            if (bus.step_idx !== e || bus.done !== 1'b0) begin
                bad++; $display("FAIL loop_idx@%0d: got idx=%0d done=%b want %0d 0", j, bus.step_idx, bus.done, e);
            end
        end
        tick();               // j=21: HOLD of step 0
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ch_val !== mk_ch(6)) begin
            bad++; $display("FAIL loop_stop: got busy=%b done=%b ch=%h want 0 0 %h", bus.busy, bus.done, bus.ch_val, mk_ch(6));
        end
    endtask

    task automatic test_clamp();
        logic [CHB-1:0] prev, e;
        int t0, et, done_n, done_t;
        for (int i = 0; i < int'(DEPTH); i++) begin
            wr_entry(i, 1'b0, 8'h00, mk_ch(10 + i), 0);
            exp_ch_q.push_back(mk_ch(10 + i)); exp_t_q.push_back(2 + 2 * i);
        end
        prev = bus.ch_val; t0 = now; done_n = 0; done_t = -1;
        go(20, 1'b0);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 0) bus.start = 1'b0;
            if (bus.ch_val !== prev) begin
                total++;
                if (exp_ch_q.size() == 0) begin
                    bad++; $display("FAIL clamp_extra: got %h @%0d want no change", bus.ch_val, now - t0);
                end else begin
                    e = exp_ch_q.pop_front(); et = exp_t_q.pop_front();
                    if (bus.ch_val !== e || now - t0 != et) begin
                        bad++; $display("FAIL clamp_ch: got %h @%0d want %h @%0d", bus.ch_val, now - t0, e, et);
                    end
                end
                prev = bus.ch_val;
            end
            if (bus.done === 1'b1) begin done_n++; done_t = now - t0; end
        end
        total++;
        if (exp_ch_q.size() != 0 || done_n != 1 || done_t != 33) begin
            bad++; $display("FAIL clamp_end: got pend=%0d done_n=%0d @%0d want 0 1 @33", exp_ch_q.size(), done_n, done_t);
        end
        exp_ch_q.delete(); exp_t_q.delete();
    endtask

    task automatic test_write_rules();
        wr_entry(0, 1'b0, 8'h00, mk_ch(30), 3);
        wr_entry(1, 1'b0, 8'h00, mk_ch(31), 3);
        go(2, 1'b0);
        tick(); bus.start = 1'b0;
        tick();
        wr_entry(0, 1'b0, 8'h00, mk_ch(32), 3);   // busy: must be dropped
        wait_idle();
        go(1, 1'b0);
        tick(); bus.start = 1'b0;
        tick();
        total++;
        if (bus.ch_val !== mk_ch(30)) begin
            bad++; $display("FAIL wr_busy: got %h want %h", bus.ch_val, mk_ch(30));
        end
        wait_idle();
        // Write and start in the same IDLE cycle: the sequence sees the new entry
        go(1, 1'b0);
        wr_entry(0, 1'b0, 8'h00, mk_ch(33), 0);
        bus.start = 1'b0;
        tick();
        total++;
        if (bus.ch_val !== mk_ch(33)) begin
            bad++; $display("FAIL wr_start: got %h want %h", bus.ch_val, mk_ch(33));
        end
        wait_idle();
    endtask

    task automatic test_start_stop_idle();
        logic [CHB-1:0] prev;
        prev = bus.ch_val;
        go(1, 1'b0);
        bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL ss_idle: got busy=%b want 0", bus.busy); end
        tick(); tick();
        total++;
        if (bus.busy !== 1'b0 || bus.ch_val !== prev) begin
            bad++; $display("FAIL ss_after: got busy=%b ch=%h want 0 %h", bus.busy, bus.ch_val, prev);
        end
    endtask

    task automatic test_rst_mid();
        int t0, sends, done_t;
        logic seen;
        wr_entry(0, 1'b1, 8'hA5, mk_ch(40), 0);
        go(1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            bus.start = 1'b0;
            seen = bus.send_cmd;
        end
        tick();   // now in WAIT_TX
        total++;
        if (!seen || bus.busy !== 1'b1) begin
            bad++; $display("FAIL rst_setup: got seen=%b busy=%b want 1 1", seen, bus.busy);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.ch_val !== '0 || bus.cmd !== 8'h00 || bus.busy !== 1'b0 || bus.step_idx !== 4'd0 ||
            bus.send_cmd !== 1'b0 || bus.done !== 1'b0 || bus.tx_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_async: got ch=%h cmd=%h busy=%b idx=%0d snd=%b done=%b err=%b want all 0",
                     bus.ch_val, bus.cmd, bus.busy, bus.step_idx, bus.send_cmd, bus.done, bus.tx_err);
        end
        tick();
        rst = 1'b0;
        // Cleared entry 0: no command, hold 0, zero channels
        t0 = now; sends = 0; done_t = -1;
        go(1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) bus.start = 1'b0;
            if (bus.send_cmd === 1'b1) sends++;
            if (bus.done === 1'b1) done_t = now - t0;
        end
        total++;
        if (sends != 0 || done_t != 3 || bus.ch_val !== '0) begin
            bad++; $display("FAIL rst_table: got sends=%0d done@%0d ch=%h want 0 @3 0", sends, done_t, bus.ch_val);
        end
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_cmd_vld = 1'b0; bus.wr_cmd = '0;
        bus.wr_ch = '0; bus.wr_hold = '0; bus.num_steps = '0; bus.loop = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.cmd_sent = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_three_steps();
        test_cmd();
        test_timeout();
        test_loop_stop();
        test_clamp();
        test_write_rules();
        test_start_stop_idle();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
